// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings and sizing constants for the iterative multiply/divide sequencer.
package muldiv_sequencer_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_ITER  = 32;
    localparam int MD_CNT_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_DZ   = 2'd3
    } state_e;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_e;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Start/operand/result bundle between the control FSM and the multiply/divide sequencer.
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             multStart;
    logic             divStart;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             busy;
    logic             done;
    logic             div0;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output multStart, divStart, opA, opB,
        input  busy, done, div0, hi, lo
    );

    modport slave (
        input  multStart, divStart, opA, opB,
        output busy, done, div0, hi, lo
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative signed multiply (shift-add) / divide (restoring) engine owning HI/LO.
// Operands are held as unsigned magnitudes; signs are reapplied on the final iteration.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = MD_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    muldiv_sequencer_if.slave bus
);

    state_e               state_q, state_d;
    op_e                  op_q, op_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic                 qsign_q, qsign_d;
    logic                 rsign_q, rsign_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 sign_a, sign_b;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH:0]       trial;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   step;
    logic [2*WIDTH-1:0]   prod_signed;

    assign sign_a = bus.opA[WIDTH-1];
    assign sign_b = bus.opB[WIDTH-1];
    assign mag_a  = sign_a ? -bus.opA : bus.opA;
    assign mag_b  = sign_b ? -bus.opB : bus.opB;

    // Shift-add: conditional add into the top half, carry re-enters at the MSB.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
    assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                               : {1'b0, acc_q[2*WIDTH-1:1]};

    // Restoring step keeps the bit shifted out of the remainder so divisors
    // above 2^(WIDTH-1) still compare correctly.
    assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    assign trial    = rem_sh - {1'b0, b_q};
    assign div_next = trial[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                   : {trial[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

    assign step        = (op_q == OP_MUL) ? mul_next : div_next;
    assign prod_signed = qsign_q ? -step : step;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        b_d     = b_q;
        qsign_d = qsign_q;
        rsign_d = rsign_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.multStart) begin
                    op_d    = OP_MUL;
                    acc_d   = {{WIDTH{1'b0}}, mag_a};
                    b_d     = mag_b;
                    qsign_d = sign_a ^ sign_b;
                    rsign_d = sign_a;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else if (bus.divStart) begin
                    if (bus.opB == '0) begin
                        state_d = ST_DZ;
                    end else begin
                        op_d    = OP_DIV;
                        acc_d   = {{WIDTH{1'b0}}, mag_a};
                        b_d     = mag_b;
                        qsign_d = sign_a ^ sign_b;
                        rsign_d = sign_a;
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                acc_d = step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                    if (op_q == OP_MUL) begin
                        {hi_d, lo_d} = prod_signed;
                    end else begin
                        lo_d = qsign_q ? -step[WIDTH-1:0] : step[WIDTH-1:0];
                        hi_d = rsign_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_DZ:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_MUL;
            cnt_q   <= '0;
            acc_q   <= '0;
            b_q     <= '0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.busy = (state_q != ST_IDLE);
    assign bus.done = (state_q == ST_DONE);
    assign bus.div0 = (state_q == ST_DZ);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized bench for muldiv_sequencer against a cycle-counting arithmetic model.
module tb_muldiv_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    muldiv_sequencer_if #(.WIDTH(32)) bus ();

    muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: edges remaining until the engine is idle again, plus the pending result.
    int          m_left = 0;
    bit          m_dz = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    longint      sa, sb, res, rem;
    logic [63:0] res_bits;
    logic        e_busy, e_done, e_div0;

    always @(posedge clk) begin
        if (reset) begin
            m_left = 0;
            m_hi   = '0;
            m_lo   = '0;
        end else if (m_left == 0) begin
            sa = $signed(bus.opA);
            sb = $signed(bus.opB);
            if (bus.multStart) begin
                res_bits = sa * sb;
                {p_hi, p_lo} = res_bits;
                m_dz   = 1'b0;
                m_left = 33;
            end else if (bus.divStart) begin
                if (bus.opB == 32'd0) begin
                    m_dz   = 1'b1;
                    m_left = 1;
                end else begin
                    res  = sa / sb;
                    rem  = sa % sb;
                    p_lo = res[31:0];
                    p_hi = rem[31:0];
                    m_dz   = 1'b0;
                    m_left = 33;
                end
            end
        end else begin
            m_left = m_left - 1;
            if (m_left == 1 && !m_dz) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end
        #1;
        e_busy = (m_left != 0);
        e_done = (m_left == 1) && !m_dz;
        e_div0 = (m_left == 1) && m_dz;
        vectors++;
        if ({bus.busy, bus.done, bus.div0, bus.hi, bus.lo} !== {e_busy, e_done, e_div0, m_hi, m_lo}) begin
            miscompares++;
            $display("FAIL cycle t=%0t busy/done/div0/hi/lo got %b%b%b %h %h want %b%b%b %h %h",
                     $time, bus.busy, bus.done, bus.div0, bus.hi, bus.lo,
                     e_busy, e_done, e_div0, m_hi, m_lo);
        end
    end

    task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic start_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.multStart = m;
        bus.divStart  = d;
        bus.opA       = a;
        bus.opB       = b;
        @(negedge clk);
        bus.multStart = 1'b0;
        bus.divStart  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 100; i++) begin
            if (!bus.busy) return;
            @(negedge clk);
        end
        vectors++;
        miscompares++;
        $display("FAIL %s timeout busy got 1 want 0", name);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 6))
            0: v = 32'h0000_0000;
            1: v = 32'h8000_0000;
            2: v = 32'hFFFF_FFFF;
            3: v = $urandom_range(0, 20);
            4: v = -$urandom_range(1, 20);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        bus.multStart = 1'b0;
        bus.divStart  = 1'b0;
        bus.opA       = '0;
        bus.opB       = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_lit("reset_busy", {31'b0, bus.busy}, 32'd0);
        check_lit("reset_hi", bus.hi, 32'd0);
        check_lit("reset_lo", bus.lo, 32'd0);

        start_op(1, 0, 32'd7, 32'hFFFF_FFFD);
        wait_idle("mul_sign");
        check_lit("mul_sign_hi", bus.hi, 32'hFFFF_FFFF);
        check_lit("mul_sign_lo", bus.lo, 32'hFFFF_FFEB);

        start_op(0, 1, 32'hFFFF_FFF9, 32'd2);
        wait_idle("div_sign");
        check_lit("div_sign_hi", bus.hi, 32'hFFFF_FFFF);
        check_lit("div_sign_lo", bus.lo, 32'hFFFF_FFFD);

        start_op(0, 1, 32'd47, 32'd7);
        wait_idle("preload");
        start_op(0, 1, 32'd99, 32'd0);
        wait_idle("div0");
        check_lit("div0_hi", bus.hi, 32'd5);
        check_lit("div0_lo", bus.lo, 32'd6);

        start_op(1, 0, 32'h8000_0000, 32'h8000_0000);
        wait_idle("mul_ext");
        check_lit("mul_ext_hi", bus.hi, 32'h4000_0000);
        check_lit("mul_ext_lo", bus.lo, 32'h0000_0000);

        start_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle("div_ext");
        check_lit("div_ext_hi", bus.hi, 32'h0000_0000);
        check_lit("div_ext_lo", bus.lo, 32'h8000_0000);

        start_op(1, 1, 32'd3, 32'd4);
        wait_idle("arb");
        check_lit("arb_hi", bus.hi, 32'd0);
        check_lit("arb_lo", bus.lo, 32'd12);

        start_op(0, 1, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        bus.divStart = 1'b1;
        bus.opB      = 32'd0;
        @(negedge clk);
        bus.divStart = 1'b0;
        wait_idle("ignore");
        check_lit("ignore_hi", bus.hi, 32'd2);
        check_lit("ignore_lo", bus.lo, 32'd14);

        start_op(1, 0, 32'd9, 32'd9);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_lit("rst_mid_busy", {31'b0, bus.busy}, 32'd0);
        check_lit("rst_mid_hi", bus.hi, 32'd0);
        check_lit("rst_mid_lo", bus.lo, 32'd0);
        reset = 1'b0;
        bus.multStart = 1'b1;
        bus.opA = 32'hFFFF_FFFA;
        bus.opB = 32'd7;
        @(negedge clk);
        bus.multStart = 1'b0;
        check_lit("post_rst_busy", {31'b0, bus.busy}, 32'd1);
        wait_idle("post_rst");
        check_lit("post_rst_hi", bus.hi, 32'hFFFF_FFFF);
        check_lit("post_rst_lo", bus.lo, 32'hFFFF_FFD6);

        for (int i = 0; i < 2000; i++) begin
            int r;
            @(negedge clk);
            r = $urandom_range(0, 15);
            bus.multStart = (r == 0);
            bus.divStart  = (r == 1) || (r == 2) || (r == 3);
            bus.opA       = pick_operand();
            bus.opB       = pick_operand();
            reset         = (i % 700 == 350);
        end
        @(negedge clk);
        bus.multStart = 1'b0;
        bus.divStart  = 1'b0;
        reset         = 1'b0;
        wait_idle("final");
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
